// File: rtl/apb_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave_if
//   APB3 bus bundle between a requester and apb_regfile_slave.
//   Signal names keep the completer's point of view (_i driven by the
//   requester, _o driven by the completer).
//   psel_i/penable_i     : select and access-phase strobe
//   paddr_i/pwrite_i     : byte address, 1 = write
//   pwdata_i             : write data
//   prdata_o             : read data, valid with pready_o on a read
//   pready_o/pslverr_o   : completion strobe and error response
// ---------------------------------------------------------------------------
interface apb_regfile_slave_if;
   logic        psel_i;
   logic        penable_i;
   logic [31:0] paddr_i;
   logic        pwrite_i;
   logic [31:0] pwdata_i;
   logic [31:0] prdata_o;
   logic        pready_o;
   logic        pslverr_o;

   modport master (
      output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB3 completer with NUM_REGS read/write 32-bit registers at byte
//   offsets 0x00..4*(NUM_REGS-1) and a read-only transfer counter
//   (XFER_CNT = {16'h0, cnt}) at index NUM_REGS. WAIT_CYCLES wait states
//   are inserted before pready_o. All outputs are registered.
//   Optional feature: define APB_SLV_ERR_EN to report out-of-range
//   accesses on pslverr_o; otherwise pslverr_o is 0 and such accesses
//   are silently dropped / read as 0.
// Ports
//   pclk   : clock, rising edge
//   preset : synchronous active-high reset
//   bus    : apb_regfile_slave_if.slave (psel/penable/paddr/pwrite/pwdata
//            in, prdata/pready/pslverr out)
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
   parameter int NUM_REGS    = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               pclk,
   input  logic               preset,
   apb_regfile_slave_if.slave bus
);

   localparam logic [3:0] CNT_IDX   = 4'(NUM_REGS);
   localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 wcnt_q, wcnt_d;
   logic [31:0]                addr_q, addr_d;
   logic [31:0]                wdata_q, wdata_d;
   logic                       write_q, write_d;
   logic [31:0]                prdata_q, prdata_d;
   logic                       pready_q, pready_d;
   logic                       pslverr_q, pslverr_d;
   logic [NUM_REGS-1:0][31:0]  regs_q;
   logic [15:0]                cnt_q;

   // Decode works on the live bus in IDLE (so a zero-wait response can be
   // built from the setup cycle) and on the latched request otherwise.
   logic [31:0] dec_addr;
   logic        dec_write;
   logic [3:0]  dec_idx;
   logic        oor;
   logic [31:0] rd_val;
   logic [31:0] resp_data;
   logic        resp_err;

   assign dec_addr  = (state_q == S_IDLE) ? bus.paddr_i  : addr_q;
   assign dec_write = (state_q == S_IDLE) ? bus.pwrite_i : write_q;
   assign dec_idx   = dec_addr[5:2];

   assign oor = (dec_addr[1:0] != 2'b00) || (dec_addr[31:6] != '0) ||
                (dec_idx > CNT_IDX) || ((dec_idx == CNT_IDX) && dec_write);

   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (dec_idx == 4'(k)) rd_val = regs_q[k];
      // Counter value sampled before this transfer's own increment.
      if (dec_idx == CNT_IDX) rd_val = {16'h0, cnt_q};
   end

   assign resp_data = (dec_write || oor) ? 32'h0 : rd_val;

`ifdef APB_SLV_ERR_EN
   assign resp_err = oor;
`else
   assign resp_err = 1'b0;
`endif

   // Next-state / next-output logic. The response registers are loaded on
   // the edge that enters RESP, so pready_o is high exactly during RESP.
   // Entering RESP when the count would reach zero on this access keeps
   // pready_o in cycle T1+WAIT_CYCLES despite the output register.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.psel_i && !bus.penable_i) begin
               addr_d  = bus.paddr_i;
               write_d = bus.pwrite_i;
               wdata_d = bus.pwdata_i;
               wcnt_d  = WCNT_INIT;
               if (WAIT_CYCLES == 0) begin
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  prdata_d  = resp_data;
                  pslverr_d = resp_err;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!bus.psel_i) begin
               state_d = S_IDLE;                  // abort, no side effects
            end else if (bus.penable_i) begin
               if (wcnt_q <= 4'd1) begin
                  state_d   = S_RESP;
                  wcnt_d    = '0;
                  pready_d  = 1'b1;
                  prdata_d  = resp_data;
                  pslverr_d = resp_err;
               end else begin
                  wcnt_d = wcnt_q - 4'd1;
               end
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Register bank and transfer counter update at the end of RESP; decode
   // there reflects the latched request.
   always_ff @(posedge pclk) begin
      if (preset) begin
         regs_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == S_RESP) begin
         cnt_q <= cnt_q + 16'd1;
         if (write_q && !oor)
            for (int k = 0; k < NUM_REGS; k++)
               if (dec_idx == 4'(k)) regs_q[k] <= wdata_q;
      end
   end

   assign bus.prdata_o  = prdata_q;
   assign bus.pready_o  = pready_q;
   assign bus.pslverr_o = pslverr_q;

endmodule
